// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_issuer
// Purpose  : Command FIFO and issue stage for the registered 4-bit ALU. Buffers
//            {op,A,B} commands, issues one per enabled cycle, and tracks the
//            in-flight commands so res_valid/res_tag line up with the ALU result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int ALU_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_a,
    input  logic [3:0]    in_b,
    input  logic [1:0]    in_op,
    input  logic          issue_en,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [1:0]    alu_op,
    output logic          issued,
    output logic          res_valid,
    output logic [3:0]    res_tag,
    output logic [AW:0]   fill
);

    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] C_ONE  = (AW + 1)'(1);

    // Storage entries are {op[1:0], a[3:0], b[3:0]}; not cleared by reset.
    logic [9:0]         mem_q [DEPTH];

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        fill_q,   fill_d;
    logic [3:0]         tag_q,    tag_d;

    // Alignment pipe: one slot per ALU register stage.
    logic [ALU_LAT-1:0] vpipe_q;
    logic [3:0]         tpipe_q [ALU_LAT];

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [9:0]         w_head;

    // Handshake decode; readiness comes only from registered occupancy.
    always_comb begin
        w_full   = (fill_q == C_FULL);
        w_empty  = (fill_q == '0);
        in_ready = ~w_full;
        w_push   = in_valid & ~w_full;
        w_pop    = issue_en & ~w_empty;
        w_head   = mem_q[rd_ptr_q];
        issued   = w_pop;
        fill     = fill_q;
    end

    // Present the FIFO head to the ALU only when it is actually issued.
    always_comb begin
        alu_a  = 4'd0;
        alu_b  = 4'd0;
        alu_op = 2'b00;
        if (w_pop) begin
            alu_op = w_head[9:8];
            alu_a  = w_head[7:4];
            alu_b  = w_head[3:0];
        end
    end

    // Next-state for pointers, occupancy and the sequence tag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        tag_d    = tag_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            tag_d    = tag_q + 4'd1;
        end
        case ({w_push, w_pop})
            2'b10:   fill_d = fill_q + C_ONE;
            2'b01:   fill_d = fill_q - C_ONE;
            default: fill_d = fill_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            tag_q    <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            tag_q    <= tag_d;
        end
    end

    // Command storage write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {in_op, in_a, in_b};
        end
    end

    // Delay issue flag and tag to match the ALU latency; the tag stage only
    // loads on issue so res_tag keeps the last result's tag while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe_q <= '0;
            for (int k = 0; k < ALU_LAT; k++) begin
                tpipe_q[k] <= 4'd0;
            end
        end else begin
            vpipe_q[0] <= w_pop;
            if (w_pop) begin
                tpipe_q[0] <= tag_q;
            end
            for (int k = 1; k < ALU_LAT; k++) begin
                vpipe_q[k] <= vpipe_q[k-1];
                tpipe_q[k] <= tpipe_q[k-1];
            end
        end
    end

    assign res_valid = vpipe_q[ALU_LAT-1];
    assign res_tag   = tpipe_q[ALU_LAT-1];

endmodule
`default_nettype wire
